mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: instruction fetch (I, read-only) and load/store (D, read/write).
- Requesters hold a level request until they receive a one-cycle ACK.
- The arbiter serialises accesses, drives the memory address/write port, and registers read data.
- Sits between the multi-cycle control/datapath and the memory, replacing direct control-driven address muxing.

Parameters:
- ADDR_W, 32, address width (byte address).
- DATA_W, 32, data word width.
- FIXED_PRIO, 0, 0 = round-robin on tie; 1 = D always wins a tie.
- CHECK_ALIGN, 1, 1 = a non-word-aligned access returns ERR with no memory write.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- I_REQ  in  1  fetch request; held high until I_ACK.
- I_ADDR  in  ADDR_W  fetch address; stable while I_REQ is high.
- I_ACK  out  1  one-cycle completion pulse for the fetch.
- D_REQ  in  1  data request; held high until D_ACK.
- D_WE  in  1  1 = store, 0 = load; stable while D_REQ is high.
- D_ADDR  in  ADDR_W  data address.
- D_WDATA  in  DATA_W  store data.
- D_ACK  out  1  one-cycle completion pulse for the data access.
- RDATA  out  DATA_W  read data; valid in the cycle that I_ACK or D_ACK is high.
- ERR  out  1  misaligned access; valid with the ACK.
- MEM_A  out  ADDR_W  memory address.
- MEM_WE  out  1  memory write enable.
- MEM_WD  out  DATA_W  memory write data.
- MEM_RD  in  DATA_W  memory read data (combinational from MEM_A).
- BUSY  out  1  high whenever state != IDLE.

Behaviour:
- Reset state: state = IDLE, last_grant = D, all other registers 0.
- Reset values of outputs: I_ACK = D_ACK = ERR = 0, RDATA = 0, MEM_A = 0, MEM_WD = 0, BUSY = 0.
- MEM_WE is combinational: (state == ACCESS) & ~RST & ~misaligned_latched & we_latched. RST therefore blocks a write in the same cycle.
- States: IDLE -> ACCESS -> RESP -> (ACCESS | IDLE).
- IDLE:
  - Arbitrate I_REQ/D_REQ.
  - If there is a winner: latch grant id, address, we (0 for I), wdata, and misaligned = CHECK_ALIGN & (addr[1:0] != 0); update last_grant; go to ACCESS.
  - If there is no request: stay in IDLE.
- Tie rule: FIXED_PRIO = 1 grants D. FIXED_PRIO = 0 grants the requester that is not last_grant.
- ACCESS (exactly 1 cycle):
  - MEM_A = latched address; MEM_WD = latched wdata.
  - A store commits at the rising edge ending this cycle.
  - RDATA is captured from MEM_RD at that same edge. For a store, RDATA is captured as 0; for a misaligned access, RDATA is 0.
  - ERR register is loaded with the latched misaligned flag.
  - Next state: RESP.
- RESP (exactly 1 cycle):
  - Assert the ACK of the granted requester; RDATA and ERR are valid.
  - Arbitrate only the other requester. If its REQ is high, latch it and go to ACCESS (back-to-back, no IDLE bubble); otherwise go to IDLE.
  - The acked requester's REQ is ignored this cycle, because it is still high from the previous handshake.
- Latency: REQ sampled in IDLE at edge N; ACK is high in cycle N+2. Sustained throughput is one access per 2 cycles.
- ACKs are mutually exclusive and never asserted outside RESP. RDATA and ERR hold their value until the next capture.
- MEM_A and MEM_WD hold their last latched value outside ACCESS. MEM_WE = 0 outside ACCESS.
- Dropping REQ before ACK is illegal; the arbiter completes the latched access regardless.
- A misaligned store performs no write and is acked with ERR = 1.
- RST in any state: next state IDLE, no ACK issued, and any in-flight write is suppressed.

Decomposition:
- Package mem_arb_pkg:
  - State localparams: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2.
  - Grant ids: GNT_I = 1'b0, GNT_D = 1'b1.
  - Alignment mask constant.
- Sub-module rr_pick2: combinational 2-way picker.
  - Inputs: req_i, req_d, last_grant, fixed_prio, exclude_valid, exclude_id.
  - Outputs: valid, grant_id.
  - Used in both IDLE and RESP arbitration.

Test Plan:
- Store then load:
  - D store 7 to addr 96 -> D_ACK two cycles after the REQ is sampled, MEM_WE high for exactly 1 cycle with MEM_A = 96 and MEM_WD = 7.
  - Then D load from 96 -> RDATA = 7, ERR = 0.
- Simultaneous first requests after reset: I fetch addr 0 and D load addr 100 (preloaded 25), FIXED_PRIO = 0 -> I_ACK first; D_ACK two cycles later with RDATA = 25; no IDLE cycle between them.
- Continuous contention:
  - Both REQs held high for 8 accesses -> ACKs strictly alternate I, D, I, D.
  - With FIXED_PRIO = 1: every tie won by D; I is served only in the RESP back-to-back slot.
- Misaligned store: D_WE = 1 to addr 98, D_WDATA = 0xDEADBEEF -> MEM_WE never high, D_ACK with ERR = 1; a subsequent load of 96 returns the old value.
- Reset mid-operation: RST asserted during ACCESS of a store of 0x55 to addr 104 -> MEM_WE = 0, no ACK, BUSY = 0 next cycle; reading 104 afterwards returns the prior contents.
- Single requester streaming: I_REQ held high with I_ADDR stepping by 4 after each ACK -> one I_ACK every 3 cycles (RESP -> IDLE -> ACCESS); RDATA matches the preloaded words.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Holds the FSM state encoding, grant ids and the word-alignment check.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] low_bits,
                                         input logic       check_en);
    return check_en & ((low_bits & ALIGN_MASK) != 2'b00);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker shared by IDLE and RESP arbitration.
// One requester can be excluded (the one just acknowledged in RESP).
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  input  logic fixed_prio,
  input  logic exclude_valid,
  input  logic exclude_id,
  output logic valid,
  output logic grant_id
);

  logic cand_i;
  logic cand_d;

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    cand_i   = req_i & ~(exclude_valid & (exclude_id == GNT_I));
    cand_d   = req_d & ~(exclude_valid & (exclude_id == GNT_D));
    valid    = cand_i | cand_d;
    grant_id = GNT_I;
    if (cand_i && cand_d) begin
      grant_id = fixed_prio ? GNT_D : ~last_grant;
    end else if (cand_d) begin
      grant_id = GNT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one memory port.
// IDLE -> ACCESS -> RESP, with a back-to-back grant to the other side in RESP.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIXED_PRIO  = 0,
  parameter int CHECK_ALIGN = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic              I_ACK,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_ACK,
  output logic [DATA_W-1:0] RDATA,
  output logic              ERR,
  output logic [ADDR_W-1:0] MEM_A,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WD,
  input  logic [DATA_W-1:0] MEM_RD,
  output logic              BUSY
);

  state_t state;
  state_t state_next;

  logic              grant_q;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mis_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              pick_valid;
  logic              pick_id;
  logic              load_en;
  logic [ADDR_W-1:0] sel_addr;

  rr_pick2 u_pick (
    .req_i         (I_REQ),
    .req_d         (D_REQ),
    .last_grant    (last_grant),
    .fixed_prio    (FIXED_PRIO != 0),
    .exclude_valid (state == RESP),
    .exclude_id    (grant_q),
    .valid         (pick_valid),
    .grant_id      (pick_id)
  );

  assign sel_addr = (pick_id == GNT_D) ? D_ADDR : I_ADDR;

  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          load_en    = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: state_next = RESP;
      RESP: begin
        if (pick_valid) begin
          load_en    = 1'b1;
          state_next = ACCESS;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      grant_q    <= GNT_I;
      last_grant <= GNT_D;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      mis_q      <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (load_en) begin
        grant_q    <= pick_id;
        last_grant <= pick_id;
        addr_q     <= sel_addr;
        we_q       <= (pick_id == GNT_D) & D_WE;
        wdata_q    <= (pick_id == GNT_D) ? D_WDATA : '0;
        mis_q      <= is_misaligned(sel_addr[1:0], CHECK_ALIGN != 0);
      end
      if (state == ACCESS) begin
        // Stores and misaligned accesses return zero rather than stale memory data.
        rdata_q <= (we_q | mis_q) ? '0 : MEM_RD;
        err_q   <= mis_q;
      end
    end
  end

  // Reset gates the write strobe and ACKs combinationally so an in-flight access is dropped.
  assign MEM_WE = (state == ACCESS) & ~RST & ~mis_q & we_q;
  assign I_ACK  = (state == RESP) & ~RST & (grant_q == GNT_I);
  assign D_ACK  = (state == RESP) & ~RST & (grant_q == GNT_D);
  assign MEM_A  = addr_q;
  assign MEM_WD = wdata_q;
  assign RDATA  = rdata_q;
  assign ERR    = err_q;
  assign BUSY   = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural memory.
// A second instance with FIXED_PRIO = 1 covers the fixed-priority tie rule.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_ack, d_ack, err, mem_we, busy;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  logic        i_req_f = 1'b0, d_req_f = 1'b0, d_we_f = 1'b0;
  logic [31:0] i_addr_f = '0, d_addr_f = '0, d_wdata_f = '0;
  logic        i_ack_f, d_ack_f, err_f, mem_we_f, busy_f;
  logic [31:0] rdata_f, mem_a_f, mem_wd_f, mem_rd_f;

  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_pass   = 0;

  int          we_count   = 0;
  int          we_count_f = 0;
  logic [31:0] we_last_a  = '0;
  logic [31:0] we_last_d  = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .CHECK_ALIGN(1)) dut (
    .CLK(clk), .RST(rst),
    .I_REQ(i_req), .I_ADDR(i_addr), .I_ACK(i_ack),
    .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata), .D_ACK(d_ack),
    .RDATA(rdata), .ERR(err),
    .MEM_A(mem_a), .MEM_WE(mem_we), .MEM_WD(mem_wd), .MEM_RD(mem_rd),
    .BUSY(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .CHECK_ALIGN(1)) dut_f (
    .CLK(clk), .RST(rst),
    .I_REQ(i_req_f), .I_ADDR(i_addr_f), .I_ACK(i_ack_f),
    .D_REQ(d_req_f), .D_WE(d_we_f), .D_ADDR(d_addr_f), .D_WDATA(d_wdata_f), .D_ACK(d_ack_f),
    .RDATA(rdata_f), .ERR(err_f),
    .MEM_A(mem_a_f), .MEM_WE(mem_we_f), .MEM_WD(mem_wd_f), .MEM_RD(mem_rd_f),
    .BUSY(busy_f)
  );

  always #5 clk = ~clk;

  assign mem_rd   = mem[mem_a[7:2]];
  assign mem_rd_f = mem_a_f ^ 32'hCAFE_0000;

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  always @(negedge clk) begin
    if (mem_we) begin
      we_count  <= we_count + 1;
      we_last_a <= mem_a;
      we_last_d <= mem_wd;
    end
    if (mem_we_f) we_count_f <= we_count_f + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er, output int lat);
    d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    lat = -1; rd = '0; er = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (d_ack) begin
        lat = c; rd = rdata; er = err;
        break;
      end
    end
    d_req = 1'b0;
    tick();
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_writes;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          i_cyc, d_cyc, idle_gap, both_cnt, we0, got;
    logic [31:0] i_rd, d_rd;
    logic        ids_m [$];
    int          cyc_m [$];
    logic [31:0] rd_m  [$];
    logic        ids_f [$];
    int          cyc_f [$];
    logic [31:0] rd_f  [$];
    int          s_cyc [$];
    logic [31:0] s_rd  [$];

    for (int k = 0; k < 64; k++) mem[k] = 32'h100 + k;
    mem[25] = 32'd25;

    vecs[0] = '{1'b1, 32'd96,  32'd7,          32'd0,          1'b0, 1};
    vecs[1] = '{1'b0, 32'd96,  32'd0,          32'd7,          1'b0, 0};
    vecs[2] = '{1'b1, 32'd98,  32'hDEAD_BEEF,  32'd0,          1'b1, 0};
    vecs[3] = '{1'b0, 32'd96,  32'd0,          32'd7,          1'b0, 0};
    vecs[4] = '{1'b0, 32'd101, 32'd0,          32'd0,          1'b1, 0};
    vecs[5] = '{1'b0, 32'd100, 32'd0,          32'd25,         1'b0, 0};
    vecs[6] = '{1'b1, 32'd0,   32'h1234_5678,  32'd0,          1'b0, 1};
    vecs[7] = '{1'b0, 32'd0,   32'd0,          32'h1234_5678,  1'b0, 0};

    // Reset values
    repeat (3) tick();
    check("rst_i_ack",  32'(i_ack),  32'd0);
    check("rst_d_ack",  32'(d_ack),  32'd0);
    check("rst_err",    32'(err),    32'd0);
    check("rst_rdata",  rdata,       32'd0);
    check("rst_mem_a",  mem_a,       32'd0);
    check("rst_mem_wd", mem_wd,      32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_busy",   32'(busy),   32'd0);

    // Simultaneous first requests: round-robin with last_grant = D picks I first
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'd0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd100;
    i_cyc = -1; d_cyc = -1; idle_gap = 0; both_cnt = 0; i_rd = '0; d_rd = '0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (i_ack && d_ack) both_cnt++;
      if (!busy) idle_gap++;
      if (i_ack) begin i_cyc = c; i_rd = rdata; i_req = 1'b0; end
      if (d_ack) begin d_cyc = c; d_rd = rdata; d_req = 1'b0; end
      if (i_cyc >= 0 && d_cyc >= 0) break;
    end
    tick();
    check("sim_i_ack_cycle", 32'(i_cyc),    32'd2);
    check("sim_d_ack_cycle", 32'(d_cyc),    32'd4);
    check("sim_i_rdata",     i_rd,          32'h100);
    check("sim_d_rdata",     d_rd,          32'd25);
    check("sim_idle_gap",    32'(idle_gap), 32'd0);
    check("sim_both_ack",    32'(both_cnt), 32'd0);

    // Table-driven single D accesses
    for (int v = 0; v < 8; v++) begin
      we0 = we_count;
      d_access(vecs[v].we, vecs[v].addr, vecs[v].wdata, rd, er, lat);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'd2);
      check($sformatf("vec%0d_rdata", v),   rd,       vecs[v].exp_rdata);
      check($sformatf("vec%0d_err", v),     32'(er),  32'(vecs[v].exp_err));
      check($sformatf("vec%0d_writes", v),  32'(we_count - we0), 32'(vecs[v].exp_writes));
      if (vecs[v].exp_writes == 1) begin
        check($sformatf("vec%0d_we_addr", v), we_last_a, vecs[v].addr);
        check($sformatf("vec%0d_we_data", v), we_last_d, vecs[v].wdata);
      end
    end

    // Fixed-priority instance: serve D alone first so a round-robin tie would favour I
    d_req_f = 1'b1; d_we_f = 1'b0; d_addr_f = 32'd12; got = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (d_ack_f) begin got = c; break; end
    end
    d_req_f = 1'b0;
    tick();
    check("fix_pre_latency", 32'(got), 32'd2);

    // Continuous contention on both instances for 8 accesses each
    i_req = 1'b1; i_addr = 32'd4; d_req = 1'b1; d_we = 1'b0; d_addr = 32'd100;
    i_req_f = 1'b1; i_addr_f = 32'd8; d_req_f = 1'b1; d_addr_f = 32'd12;
    both_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if ((i_ack && d_ack) || (i_ack_f && d_ack_f)) both_cnt++;
      if (i_ack || d_ack) begin
        ids_m.push_back(d_ack); cyc_m.push_back(c); rd_m.push_back(rdata);
      end
      if (i_ack_f || d_ack_f) begin
        ids_f.push_back(d_ack_f); cyc_f.push_back(c); rd_f.push_back(rdata_f);
      end
    end
    i_req = 1'b0; d_req = 1'b0; i_req_f = 1'b0; d_req_f = 1'b0;
    tick();
    check("cont_both_ack", 32'(both_cnt),     32'd0);
    check("cont_rr_count", 32'(ids_m.size()), 32'd8);
    check("cont_fp_count", 32'(ids_f.size()), 32'd8);
    check("cont_fp_writes", 32'(we_count_f),  32'd0);
    for (int k = 0; k < ids_m.size(); k++) begin
      check($sformatf("cont_rr%0d_id", k),    32'(ids_m[k]), 32'(k % 2));
      check($sformatf("cont_rr%0d_cycle", k), 32'(cyc_m[k]), 32'(2 + 2 * k));
      check($sformatf("cont_rr%0d_rdata", k), rd_m[k], (k % 2 == 1) ? 32'd25 : 32'h101);
    end
    for (int k = 0; k < ids_f.size(); k++) begin
      check($sformatf("cont_fp%0d_id", k),    32'(ids_f[k]), 32'((k + 1) % 2));
      check($sformatf("cont_fp%0d_cycle", k), 32'(cyc_f[k]), 32'(2 + 2 * k));
      check($sformatf("cont_fp%0d_rdata", k), rd_f[k],
            (k % 2 == 0) ? 32'hCAFE_000C : 32'hCAFE_0008);
    end

    // Single requester streaming: one I_ACK every 3 cycles
    i_req = 1'b1; i_addr = 32'd8;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (i_ack) begin
        s_cyc.push_back(c); s_rd.push_back(rdata);
        i_addr = i_addr + 32'd4;
        if (s_cyc.size() == 4) begin i_req = 1'b0; break; end
      end
    end
    i_req = 1'b0;
    tick();
    check("stream_count", 32'(s_cyc.size()), 32'd4);
    for (int k = 0; k < s_cyc.size(); k++) begin
      check($sformatf("stream%0d_cycle", k), 32'(s_cyc[k]), 32'(2 + 3 * k));
      check($sformatf("stream%0d_rdata", k), s_rd[k], 32'h102 + 32'(k));
    end

    // Reset during the ACCESS cycle of a store
    we0 = we_count;
    d_we = 1'b1; d_addr = 32'd104; d_wdata = 32'h55; d_req = 1'b1;
    tick();
    check("rmid_busy_access", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rmid_mem_we", 32'(mem_we), 32'd0);
    check("rmid_ack_during", 32'(d_ack | i_ack), 32'd0);
    tick();
    check("rmid_busy_after", 32'(busy),  32'd0);
    check("rmid_no_ack",     32'(d_ack), 32'd0);
    rst = 1'b0; d_req = 1'b0;
    tick();
    check("rmid_writes", 32'(we_count - we0), 32'd0);
    d_access(1'b0, 32'd104, 32'd0, rd, er, lat);
    check("rmid_reload_rdata",   rd,       32'h11A);
    check("rmid_reload_err",     32'(er),  32'd0);
    check("rmid_reload_latency", 32'(lat), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
